// File: rtl/axlite2wb_pkg.sv
// Shared types and helpers for the AXI-Lite to Wishbone write path.
package axlite2wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } walk_state_e;

  // Index width for a WIDTH-bit vector, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned w);
    int unsigned r;
    r = $clog2(w);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus a
// flag that is high when exactly one bit of the vector is set.
module lowest_set_index
  import axlite2wb_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
    single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/strobe_lane_walker.sv
// Captures a strobe mask and emits the index of every set bit, lowest
// first, one per output handshake, together with the mask's ones count.
module strobe_lane_walker
  import axlite2wb_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_first,
  output logic             out_last,
  output logic [IDX_W:0]   total,
  output logic             zero_pulse
);

  walk_state_e      state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W:0]   total_q, total_d;
  logic             first_q, first_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] low_idx;
  logic             low_single;
  logic [IDX_W:0]   ones;

  lowest_set_index #(.WIDTH(WIDTH)) u_lsi (
    .vec    (rem_q),
    .idx    (low_idx),
    .single (low_single)
  );

  // Ones count of the offered mask, used only at accept time.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + {{IDX_W{1'b0}}, in_mask[i]};
    end
  end

  // Next-state logic for capture and walk.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    total_d = total_q;
    first_d = first_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_mask;
          total_d = ones;
          first_d = 1'b1;
          if (in_mask != '0) state_d = WALK;
          else               zero_d  = 1'b1;
        end
      end
      WALK: begin
        if (out_ready) begin
          // Clearing the lowest set bit is the same as clearing bit out_idx.
          rem_d   = rem_q & (rem_q - WIDTH'(1));
          first_d = 1'b0;
          if (low_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      total_q <= '0;
      first_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      first_q <= first_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == WALK);
    out_idx    = low_idx;
    out_first  = out_valid & first_q;
    out_last   = out_valid & low_single;
    total      = total_q;
    zero_pulse = zero_q;
  end

endmodule

// File: tb/tb_strobe_lane_walker.sv
// Scoreboard bench for strobe_lane_walker (WIDTH=4 and WIDTH=8 instances).
module tb_strobe_lane_walker;

  typedef struct {
    int idx;
    bit first;
    bit last;
    int total;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, ir4, ov4, or4, of4, ol4, zp4;
  logic [3:0] m4;
  logic [1:0] idx4;
  logic [2:0] tot4;
  logic       iv8, ir8, ov8, or8, of8, ol8, zp8;
  logic [7:0] m8;
  logic [2:0] idx8;
  logic [3:0] tot8;

  strobe_lane_walker #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_mask(m4),
    .out_valid(ov4), .out_ready(or4), .out_idx(idx4), .out_first(of4),
    .out_last(ol4), .total(tot4), .zero_pulse(zp4)
  );

  strobe_lane_walker #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_mask(m8),
    .out_valid(ov8), .out_ready(or8), .out_idx(idx8), .out_first(of8),
    .out_last(ol8), .total(tot8), .zero_pulse(zp8)
  );

  int    tests = 0;
  int    fails = 0;
  beat_t q4[$];
  beat_t q8[$];
  int    zero_seen = 0;
  int    zero_exp  = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input int i, input bit f, input bit l, input int t);
    beat_t b;
    b.idx = i; b.first = f; b.last = l; b.total = t;
    return b;
  endfunction

  // Monitor for the 4-bit instance: scoreboard pops plus stall stability.
  bit hv = 1'b0;
  int hidx;
  bit hf, hl;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hv = 1'b0;
    end else begin
      if (zp4) zero_seen++;
      if (hv) begin
        if (!ov4) chk("hold_valid4", 0, 1);
        else begin
          chk("hold_idx4", idx4, hidx);
          chk("hold_first4", of4, hf);
          chk("hold_last4", ol4, hl);
        end
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("unexpected_beat4", idx4, -1);
        else begin
          e = q4.pop_front();
          chk("idx4", idx4, e.idx);
          chk("first4", of4, e.first);
          chk("last4", ol4, e.last);
          chk("total4", tot4, e.total);
        end
      end
      hv = ov4 && !or4;
      hidx = idx4; hf = of4; hl = ol4;
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) chk("unexpected_beat8", idx8, -1);
      else begin
        e = q8.pop_front();
        chk("idx8", idx8, e.idx);
        chk("first8", of8, e.first);
        chk("last8", ol8, e.last);
        chk("total8", tot8, e.total);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; m4 = '0; or4 = 1'b0;
    iv8 = 1'b0; m8 = '0; or8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_idx", idx4, 0);
    chk("rst_out_first", of4, 0);
    chk("rst_out_last", ol4, 0);
    chk("rst_total", tot4, 0);
    chk("rst_zero_pulse", zp4, 0);
    tick;
    rst = 1'b0;

    // 4'b1010 with out_ready high
    iv4 = 1'b1; m4 = 4'b1010; or4 = 1'b1;
    q4.push_back(mk(1, 1, 0, 2));
    q4.push_back(mk(3, 0, 1, 2));
    @(negedge clk); chk("a_accept_ready", ir4, 1);
    tick; iv4 = 1'b0;
    @(negedge clk); chk("a_n1_in_ready", ir4, 0);
    chk("a_n1_out_valid", ov4, 1);
    tick;
    tick;
    @(negedge clk);
    chk("a_n3_in_ready", ir4, 1);
    chk("a_n3_out_valid", ov4, 0);
    chk("a_drained", q4.size(), 0);

    // all-zero mask
    iv4 = 1'b1; m4 = 4'b0000; zero_exp++;
    tick; iv4 = 1'b0;
    @(negedge clk);
    chk("b_zero_pulse", zp4, 1);
    chk("b_out_valid", ov4, 0);
    chk("b_in_ready", ir4, 1);
    chk("b_total", tot4, 0);
    tick;
    @(negedge clk);
    chk("b_zero_pulse_gone", zp4, 0);
    chk("b_in_ready2", ir4, 1);

    // all-ones mask with out_ready toggling
    iv4 = 1'b1; m4 = 4'b1111; or4 = 1'b0;
    q4.push_back(mk(0, 1, 0, 4));
    q4.push_back(mk(1, 0, 0, 4));
    q4.push_back(mk(2, 0, 0, 4));
    q4.push_back(mk(3, 0, 1, 4));
    tick; iv4 = 1'b0;
    for (int k = 0; k < 20 && q4.size() > 0; k++) begin
      or4 = (k % 2 == 0);
      tick;
    end
    chk("c_drained", q4.size(), 0);
    or4 = 1'b1;
    @(negedge clk);
    chk("c_in_ready", ir4, 1);
    chk("c_total", tot4, 4);

    // back-to-back 4'b0001 then 4'b1000, in_valid held
    iv4 = 1'b1; m4 = 4'b0001;
    q4.push_back(mk(0, 1, 1, 1));
    q4.push_back(mk(3, 1, 1, 1));
    tick; m4 = 4'b1000;
    @(negedge clk); chk("d_first_walk", ov4, 1);
    tick;
    @(negedge clk);
    chk("d_bubble_valid", ov4, 0);
    chk("d_bubble_ready", ir4, 1);
    tick; iv4 = 1'b0;
    @(negedge clk); chk("d_second_walk", ov4, 1);
    tick;
    @(negedge clk);
    chk("d_drained", q4.size(), 0);
    chk("d_idle", ov4, 0);

    // 4'b0110 with reset after the first beat
    iv4 = 1'b1; m4 = 4'b0110; or4 = 1'b1;
    q4.push_back(mk(1, 1, 0, 2));
    tick; iv4 = 1'b0;
    tick; rst = 1'b1; or4 = 1'b0;
    tick; rst = 1'b0;
    @(negedge clk);
    chk("e_out_valid", ov4, 0);
    chk("e_in_ready", ir4, 1);
    chk("e_total", tot4, 0);
    chk("e_out_first", of4, 0);
    or4 = 1'b1;
    repeat (3) tick;
    chk("e_drained", q4.size(), 0);

    // WIDTH=8, 8'h81, mask changes during the walk are ignored
    iv8 = 1'b1; m8 = 8'h81; or8 = 1'b1;
    q8.push_back(mk(0, 1, 0, 2));
    q8.push_back(mk(7, 0, 1, 2));
    tick; m8 = 8'hFF;
    tick; iv8 = 1'b0;
    tick;
    tick;
    @(negedge clk);
    chk("f_drained", q8.size(), 0);
    chk("f_in_ready", ir8, 1);
    chk("f_total", tot8, 2);

    chk("zero_pulse_count", zero_seen, zero_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/strobe_lane_walker.md
# strobe_lane_walker

- Walks a captured bit mask (typically an AXI-Lite WSTRB byte-strobe word) and emits the index of every set bit, one per handshake, lowest index first.
- Provides the per-lane sequencing needed to break a multi-byte write into single-lane bus transactions.
- Sits between the AXI-Lite write channel capture and the Wishbone/I2C transaction generator.
- Reports the total ones count alongside the walk so downstream logic can size the burst.

## Interface
Parameters:
- WIDTH, 4, mask width in bits (≥2).
- IDX_W, localparam = $clog2(WIDTH), index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  mask offered.
- in_ready  out  1  block can accept a mask.
- in_mask  in  WIDTH  mask to walk.
- out_valid  out  1  out_idx valid.
- out_ready  in  1  downstream accepts out_idx.
- out_idx  out  IDX_W  index of current lowest set bit.
- out_first  out  1  current beat is first of the mask.
- out_last  out  1  current beat is last of the mask.
- total  out  IDX_W+1  ones count of the captured mask; held until next accept.
- zero_pulse  out  1  one-cycle pulse: an all-zero mask was accepted.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - WALK: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready.
  - On accept, register the mask into rem, compute and register total, and set first_flag=1.
  - If the mask ≠ 0, go to WALK.
  - If the mask = 0, stay in IDLE, set total=0, and assert zero_pulse on the next cycle only.
- In WALK:
  - out_idx = index of the lowest set bit in rem (priority encode).
  - out_last = (rem has exactly one bit set).
  - out_first = first_flag.
- Beat = out_valid & out_ready.
  - On a beat, clear the bit at out_idx in rem and clear first_flag.
  - If out_last, go to IDLE.
- Holding behaviour: while out_valid=1 and out_ready=0, out_idx, out_first and out_last hold stable. out_valid never drops without a beat, except on reset.
- Inputs in_valid and in_mask are ignored outside IDLE.
- Reset, including mid-walk:
  - State returns to IDLE. rem, total and first_flag are cleared.
  - Remaining indices are discarded; no beat is emitted for them.
- All-ones mask: emits 0..WIDTH-1 in order and total=WIDTH. total is IDX_W+1 bits wide so this value never wraps.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_first=0, out_last=0, total=0, zero_pulse=0.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one index per cycle while out_ready=1. A mask with k ones occupies WALK for k cycles minimum.
- One-cycle bubble between masks: after the last beat in cycle M, in_ready=1 in M+1, and the next accept can occur no earlier than M+1.
- in_ready is registered state, with no combinational path from out_ready.
- out_idx, out_first and out_last are combinational from registered rem/first_flag only; there is no input-to-output combinational path.
- zero_pulse is high in cycle N+1 for a zero mask accepted in cycle N.

## Structure
- Shared package `axlite2wb_pkg`:
  - state enum (IDLE, WALK);
  - helper function computing index width with a floor of 1.
- One sub-module `lowest_set_index`: combinational priority encoder taking WIDTH bits and producing an IDX_W index plus a `single` flag (exactly one bit set). It is instantiated once on rem.
- The total count is computed inline at accept time; no second sub-module.

## Test plan
- Mask 4'b1010, out_ready=1:
  - accept in cycle N;
  - beats in cycles N+1 and N+2 with idx=1 then 3;
  - first/last = 1/0 then 0/1;
  - total=2;
  - in_ready=1 in N+3.
- Mask 4'b0000:
  - no out_valid;
  - zero_pulse=1 for exactly cycle N+1;
  - total=0;
  - in_ready stays 1.
- Mask 4'b1111 with out_ready toggling 1,0,1,0,…:
  - idx sequence 0,1,2,3 with values held stable during stalls;
  - total=4;
  - out_last only on idx=3.
- Back-to-back masks 4'b0001 then 4'b1000, in_valid held high:
  - idx=0 with first=last=1;
  - one IDLE cycle;
  - then idx=3 with first=last=1.
- Mask 4'b0110, rst asserted after the first beat:
  - next cycle out_valid=0, in_ready=1, total=0;
  - idx=2 is never emitted.
- WIDTH=8, mask 8'h81:
  - idx=0 then 7;
  - total=2;
  - in_mask changes during WALK are ignored.
